// File: rtl/spm_param.sv
// Serial-parallel multiplier: MC is used in parallel, MP is consumed LSB first, one bit per clock.
// The 2*WIDTH-bit product is presented with a one-cycle done pulse WIDTH edges after start is accepted.
module spm_param #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sgn,
   input  logic [WIDTH-1:0]     MP,
   input  logic [WIDTH-1:0]     MC,
   output logic [2*WIDTH-1:0]   P,
   output logic                 done,
   output logic                 busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [PW-1:0] acc_q,   acc_d;
   logic [WIDTH-1:0] mp_q, mp_d;
   logic [PW-1:0] mcs_q,   mcs_d;
   logic          sgn_q,   sgn_d;
   logic [PW-1:0] p_q,     p_d;
   logic          done_q,  done_d;

   logic          last_bit;
   logic [PW-1:0] term;
   logic [PW-1:0] acc_next;

   // Handshake: start is taken on any edge where the block is not in RUN (IDLE or the
   // DONE cycle); requests during RUN are dropped. done pulses for one cycle with P valid,
   // and P holds until the next result is written.
   always_comb begin
      last_bit = (cnt_q == CNT_LAST);
      term     = mp_q[0] ? mcs_q : '0;
      // The MSB of a two's-complement multiplier carries negative weight.
      acc_next = (last_bit && sgn_q) ? (acc_q - term) : (acc_q + term);

      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mp_d    = mp_q;
      mcs_d   = mcs_q;
      sgn_d   = sgn_q;
      p_d     = p_q;
      done_d  = 1'b0;

      case (state_q)
         ST_RUN: begin
            acc_d = acc_next;
            mp_d  = mp_q >> 1;
            mcs_d = mcs_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (last_bit) begin
               state_d = ST_DONE;
               p_d     = acc_next;
               done_d  = 1'b1;
            end
         end
         default: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               acc_d   = '0;
               mp_d    = MP;
               mcs_d   = {{WIDTH{sgn & MC[WIDTH-1]}}, MC};
               sgn_d   = sgn;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mp_q    <= '0;
         mcs_q   <= '0;
         sgn_q   <= 1'b0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mp_q    <= mp_d;
         mcs_q   <= mcs_d;
         sgn_q   <= sgn_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   assign P    = p_q;
   assign done = done_q;
   assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_spm_param.sv
// Bench for spm_param: 32-bit and 4-bit instances, directed cases plus random operands
// compared against a plain-multiplication reference.
module tb_spm_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, sgn;
   logic [31:0] mp, mc;
   logic [63:0] p;
   logic        done, busy;
   logic        start4, sgn4;
   logic [3:0]  mp4, mc4;
   logic [7:0]  p4;
   logic        done4, busy4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spm_param #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .sgn(sgn),
      .MP(mp), .MC(mc), .P(p), .done(done), .busy(busy)
   );

   spm_param #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .sgn(sgn4),
      .MP(mp4), .MC(mc4), .P(p4), .done(done4), .busy(busy4)
   );

   function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb;
      ea = s ? {{32{a[31]}}, a} : {32'b0, a};
      eb = s ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
   endfunction

   function automatic logic [7:0] ref4(input logic s, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] ea, eb;
      ea = s ? {{4{a[3]}}, a} : {4'b0, a};
      eb = s ? {{4{b[3]}}, b} : {4'b0, b};
      return ea * eb;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One 32-bit operation; poke_at pulses start with junk operands during RUN.
   task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, output logic [63:0] res);
      int n, busy_n;
      logic hold_bad;
      logic [63:0] p_before;
      p_before = p;
      sgn = s; mp = a; mc = b; start = 1'b1;
      step();
      start = 1'b0; sgn = 1'($urandom); mp = $urandom; mc = $urandom;
      n = 0; busy_n = 0; hold_bad = 1'b0;
      while (!done && n < 200) begin
         if (busy) busy_n++;
         if (p !== p_before) hold_bad = 1'b1;
         start = (n == poke_at);
         step();
         n++;
      end
      start = 1'b0;
      chk("lat32", 64'(n), 64'd32);
      chk("busy_cycles32", 64'(busy_n), 64'd32);
      chk("p_no_partial32", {63'b0, hold_bad}, 64'd0);
      chk("busy_low_at_done32", {63'b0, busy}, 64'd0);
      res = p;
   endtask

   task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b, output logic [7:0] res);
      int n;
      sgn4 = s; mp4 = a; mc4 = b; start4 = 1'b1;
      step();
      start4 = 1'b0; mp4 = 4'($urandom); mc4 = 4'($urandom);
      n = 0;
      while (!done4 && n < 50) begin
         step();
         n++;
      end
      chk("lat4", 64'(n), 64'd4);
      res = p4;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] r;
      logic [7:0]  r4;
      logic        s;
      logic [31:0] a, b;
      int          n, n2, poke;
      logic        seen_done;

      rst = 1'b1; start = 1'b0; sgn = 1'b0; mp = '0; mc = '0;
      start4 = 1'b0; sgn4 = 1'b0; mp4 = '0; mc4 = '0;
      step(); step();
      chk("reset_p", p, 64'd0);
      chk("reset_done", {63'b0, done}, 64'd0);
      chk("reset_busy", {63'b0, busy}, 64'd0);
      chk("reset_p4", {56'b0, p4}, 64'd0);

      // start together with rst must not be accepted
      start = 1'b1; mp = 32'd3; mc = 32'd3;
      step();
      chk("rst_beats_start", {63'b0, busy}, 64'd0);
      rst = 1'b0; start = 1'b0;
      step();
      chk("idle_after_rst", {63'b0, busy}, 64'd0);

      run32(1'b0, 32'd2, 32'd3, -1, r);
      chk("t1_p", r, 64'h6);
      step();
      chk("t1_done_single", {63'b0, done}, 64'd0);
      repeat (10) step();
      chk("t1_p_hold", p, 64'h6);
      chk("t1_idle", {63'b0, busy}, 64'd0);

      run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, r);
      chk("t2_unsigned", r, 64'hFFFF_FFFE_0000_0001);
      run32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, r);
      chk("t2_signed", r, 64'h1);
      run32(1'b1, 32'hFFFF_FFFE, 32'd3, 5, r);
      chk("t3_neg", r, 64'hFFFF_FFFF_FFFF_FFFA);
      run32(1'b1, 32'h8000_0000, 32'h8000_0000, 31, r);
      chk("t3_min", r, 64'h4000_0000_0000_0000);

      // start held high: operand change during RUN ignored, back-to-back accept in DONE
      sgn = 1'b0; mp = 32'd5; mc = 32'd7; start = 1'b1;
      step();
      n = 0;
      while (!done && n < 200) begin
         if (n == 10) begin mp = 32'd9; mc = 32'd9; end
         step();
         n++;
      end
      chk("t4_lat1", 64'(n), 64'd32);
      chk("t4_p1", p, 64'd35);
      step();
      start = 1'b0;
      chk("t4_b2b_busy", {63'b0, busy}, 64'd1);
      chk("t4_p_kept", p, 64'd35);
      n2 = 0;
      while (!done && n2 < 200) begin
         step();
         n2++;
      end
      chk("t4_lat2", 64'(n2), 64'd32);
      chk("t4_p2", p, 64'd81);

      // reset in the middle of RUN discards the operation
      sgn = 1'b0; mp = 32'd1234; mc = 32'd5678; start = 1'b1;
      step();
      start = 1'b0;
      repeat (14) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_p_cleared", p, 64'd0);
      chk("t5_busy", {63'b0, busy}, 64'd0);
      seen_done = done;
      repeat (40) begin
         step();
         if (done) seen_done = 1'b1;
      end
      chk("t5_no_done", {63'b0, seen_done}, 64'd0);
      run32(1'b0, 32'd4, 32'd4, -1, r);
      chk("t5_after", r, 64'd16);

      run4(1'b1, 4'h8, 4'h7, r4);
      chk("t6_signed", {56'b0, r4}, 64'hC8);
      run4(1'b0, 4'h8, 4'h7, r4);
      chk("t6_unsigned", {56'b0, r4}, 64'h38);

      repeat (40) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: b = 32'hFFFF_FFFF;
            default: ;
         endcase
         poke = $urandom_range(0, 40);
         run32(s, a, b, poke, r);
         chk("rand32", r, ref32(s, a, b));
         repeat ($urandom_range(0, 3)) step();
      end

      repeat (30) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom;
         run4(s, a[3:0], b[3:0], r4);
         chk("rand4", {56'b0, r4}, {56'b0, ref4(s, a[3:0], b[3:0])});
         repeat ($urandom_range(0, 2)) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
